// File: rtl/player_motion_ctrl.sv
// Player movement engine: 2-axis position stepped on an internal movement tick,
// hold-to-accelerate speed ramp per axis, clamp or wrap at playfield bounds.
// Latency: buttons are seen 2 clocks after they change; position and tick update on the same edge.
// Backpressure: none. enable=0 freezes counter, position and speed; load re-homes the sprite.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   enable, load            run/freeze, synchronous reposition to START (load wins)
//   left, right, up, down   asynchronous active-high buttons (up decreases y)
//   x_val, y_val            registered position
//   tick                    1-clock pulse on each movement tick
//   moving                  either axis speed non-zero
//   at_xmin..at_ymax        position sits on that bound
module player_motion_ctrl #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 160,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 119,
  parameter int X_START     = 0,
  parameter int Y_START     = 112,
  parameter int TICK_DIV    = 3_125_000,
  parameter int MAX_SPEED   = 4,
  parameter int ACCEL_TICKS = 4,
  parameter int WRAP        = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic           load,
  input  logic           left,
  input  logic           right,
  input  logic           up,
  input  logic           down,
  output logic [X_W-1:0] x_val,
  output logic [Y_W-1:0] y_val,
  output logic           tick,
  output logic           moving,
  output logic           at_xmin,
  output logic           at_xmax,
  output logic           at_ymin,
  output logic           at_ymax
);

  // Two guard bits above the wider axis keep pos +/- speed free of overflow.
  localparam int AW = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int HW = (ACCEL_TICKS > 2) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic signed [AW-1:0] X_LO   = AW'(X_MIN);
  localparam logic signed [AW-1:0] X_HI   = AW'(X_MAX);
  localparam logic signed [AW-1:0] X_SPAN = AW'(X_MAX - X_MIN + 1);
  localparam logic signed [AW-1:0] Y_LO   = AW'(Y_MIN);
  localparam logic signed [AW-1:0] Y_HI   = AW'(Y_MAX);
  localparam logic signed [AW-1:0] Y_SPAN = AW'(Y_MAX - Y_MIN + 1);

  localparam int B_LEFT  = 0;
  localparam int B_RIGHT = 1;
  localparam int B_UP    = 2;
  localparam int B_DOWN  = 3;

  // Per-axis motion state: last direction (1 = towards MIN), speed, hold count.
  typedef struct packed {
    logic          neg;
    logic [SW-1:0] spd;
    logic [HW-1:0] hold;
  } axis_t;

  logic [3:0]     btn_s1_q, btn_s2_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tick_q, step;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  axis_t          xa_q, xa_d, ya_q, ya_d;

  // Speed ramp for one axis, evaluated once per movement tick.
  function automatic axis_t ramp(input logic plus, input logic minus, input axis_t cur);
    axis_t nxt;
    nxt = cur;
    if (plus == minus) begin
      nxt.spd  = '0;
      nxt.hold = '0;
    end else if (cur.spd == '0 || cur.neg != minus) begin
      // fresh press or reversal restarts the ramp
      nxt.neg  = minus;
      nxt.spd  = SW'(1);
      nxt.hold = '0;
    end else if (cur.hold == HW'(ACCEL_TICKS - 1)) begin
      nxt.hold = '0;
      if (cur.spd < SW'(MAX_SPEED)) begin
        nxt.spd = cur.spd + 1'b1;
      end
    end else begin
      nxt.hold = cur.hold + 1'b1;
    end
    return nxt;
  endfunction

  // New position after one step; clamps or wraps once across the span.
  function automatic logic signed [AW-1:0] move(
    input logic signed [AW-1:0] pos,
    input logic [SW-1:0]        spd,
    input logic                 neg,
    input logic signed [AW-1:0] lo,
    input logic signed [AW-1:0] hi,
    input logic signed [AW-1:0] span
  );
    logic signed [AW-1:0] delta, sum;
    delta = $signed({{(AW - SW){1'b0}}, spd});
    sum   = neg ? (pos - delta) : (pos + delta);
    if (sum > hi) begin
      if (WRAP != 0) sum = sum - span;
      else           sum = hi;
    end else if (sum < lo) begin
      if (WRAP != 0) sum = sum + span;
      else           sum = lo;
    end
    return sum;
  endfunction

  // A tick fires when the counter expires while running; load swallows it.
  assign step = enable && (cnt_q == '0) && !load;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(TICK_DIV - 1);
    end else if (enable) begin
      cnt_d = (cnt_q == '0) ? CW'(TICK_DIV - 1) : (cnt_q - 1'b1);
    end
  end

  always_comb begin
    xa_d = xa_q;
    ya_d = ya_q;
    x_d  = x_q;
    y_d  = y_q;
    if (load) begin
      xa_d = '0;
      ya_d = '0;
      x_d  = X_W'(X_START);
      y_d  = Y_W'(Y_START);
    end else if (step) begin
      xa_d = ramp(btn_s2_q[B_RIGHT], btn_s2_q[B_LEFT], xa_q);
      ya_d = ramp(btn_s2_q[B_DOWN], btn_s2_q[B_UP], ya_q);
      // position moves by the speed just computed, so a new press moves 1 at once
      x_d  = X_W'(move($signed({{(AW - X_W){1'b0}}, x_q}), xa_d.spd, xa_d.neg,
                       X_LO, X_HI, X_SPAN));
      y_d  = Y_W'(move($signed({{(AW - Y_W){1'b0}}, y_q}), ya_d.spd, ya_d.neg,
                       Y_LO, Y_HI, Y_SPAN));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      cnt_q    <= CW'(TICK_DIV - 1);
      tick_q   <= 1'b0;
      x_q      <= X_W'(X_START);
      y_q      <= Y_W'(Y_START);
      xa_q     <= '0;
      ya_q     <= '0;
    end else begin
      btn_s1_q <= {down, up, right, left};
      btn_s2_q <= btn_s1_q;
      cnt_q    <= cnt_d;
      tick_q   <= step;
      x_q      <= x_d;
      y_q      <= y_d;
      xa_q     <= xa_d;
      ya_q     <= ya_d;
    end
  end

  assign x_val   = x_q;
  assign y_val   = y_q;
  assign tick    = tick_q;
  assign moving  = (xa_q.spd != '0) || (ya_q.spd != '0);
  assign at_xmin = (x_q == X_W'(X_MIN));
  assign at_xmax = (x_q == X_W'(X_MAX));
  assign at_ymin = (y_q == Y_W'(Y_MIN));
  assign at_ymax = (y_q == Y_W'(Y_MAX));

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: four instances (TICK_DIV=4, ACCEL_TICKS=2, MAX_SPEED=3)
// differing in start x and edge mode. Stimulus pushes expected per-tick state into a
// scoreboard queue per instance; a monitor pops and compares on every tick pulse.
module tb_player_motion_ctrl;

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic        mov;
    logic [15:0] gap;   // expected clocks since previous tick, 0 = not checked
  } exp_t;

  logic       clock, reset, enable;
  logic [3:0] ld;
  logic       b_l, b_r, b_u, b_d;
  logic [7:0] xv [4];
  logic [6:0] yv [4];
  logic       tk [4];
  logic       mv [4];
  logic       axn [4];
  logic       axx [4];
  logic       ayn [4];
  logic       ayx [4];

  exp_t sbq [4][$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   last_tick [4];

  // u0: x from 0, clamp; u1: x from 146, clamp; u2: x from 147, wrap; u3: x from 10, wrap
  for (genvar g = 0; g < 4; g++) begin : g_dut
    player_motion_ctrl #(
      .TICK_DIV(4), .ACCEL_TICKS(2), .MAX_SPEED(3),
      .X_START(g == 0 ? 0 : g == 1 ? 146 : g == 2 ? 147 : 10),
      .WRAP(g >= 2 ? 1 : 0)
    ) u_dut (
      .clock(clock), .reset(reset), .enable(enable), .load(ld[g]),
      .left(b_l), .right(b_r), .up(b_u), .down(b_d),
      .x_val(xv[g]), .y_val(yv[g]), .tick(tk[g]), .moving(mv[g]),
      .at_xmin(axn[g]), .at_xmax(axx[g]), .at_ymin(ayn[g]), .at_ymax(ayx[g])
    );
  end

  function automatic int xs_of(input int g);
    case (g)
      0:       return 0;
      1:       return 146;
      2:       return 147;
      default: return 10;
    endcase
  endfunction

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every tick pulse must match the oldest expected entry for that instance.
  always @(negedge clock) begin
    exp_t e;
    for (int g = 0; g < 4; g++) begin
      if (tk[g]) begin
        if (sbq[g].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_tick u%0d: got x=%0d y=%0d, required no tick", g, xv[g], yv[g]);
        end else begin
          e = sbq[g].pop_front();
          n_chk++;
          if ({xv[g], yv[g], mv[g], axn[g], axx[g], ayn[g], ayx[g]} !==
              {e.x, e.y, e.mov, e.x == 8'd0, e.x == 8'd160, e.y == 7'd0, e.y == 7'd119}) begin
            n_fail++;
            $display("FAIL tick_u%0d: got x=%0d y=%0d mov=%0d flags=%b%b%b%b, required x=%0d y=%0d mov=%0d flags=%b%b%b%b",
                     g, xv[g], yv[g], mv[g], axn[g], axx[g], ayn[g], ayx[g],
                     e.x, e.y, e.mov, e.x == 8'd0, e.x == 8'd160, e.y == 7'd0, e.y == 7'd119);
          end
          if (e.gap != 16'd0) begin
            n_chk++;
            if (cyc - last_tick[g] != int'(e.gap)) begin
              n_fail++;
              $display("FAIL tick_gap_u%0d: got %0d clocks, required %0d", g, cyc - last_tick[g], e.gap);
            end
          end
        end
        last_tick[g] = cyc;
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int g, input int x, input int y, input bit mov, input int gap);
    exp_t e;
    e.x   = 8'(x);
    e.y   = 7'(y);
    e.mov = mov;
    e.gap = 16'(gap);
    sbq[g].push_back(e);
  endtask

  // Expect a run of x positions on instance g at y=112, moving, 4 clocks apart.
  task automatic push_xs(input int g, input int xs[$], input bit first_of_phase);
    foreach (xs[i]) push(g, xs[i], 112, 1'b1, (i == 0 && first_of_phase) ? 0 : 4);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expected ticks never arrived", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size());
      for (int g = 0; g < 4; g++) sbq[g].delete();
    end
  endtask

  task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
    @(negedge clock);
    {b_l, b_r, b_u, b_d} = {l, r, u, d};
  endtask

  // Park every instance, then release instance g with the given buttons held.
  // The first tick follows 4 clocks after the load edge.
  task automatic start_phase(input int g, input bit l, input bit r, input bit u, input bit d);
    @(negedge clock);
    ld = 4'hF;
    {b_l, b_r, b_u, b_d} = {l, r, u, d};
    @(negedge clock);
    ld[g] = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    ld     = 4'hF;
    {b_l, b_r, b_u, b_d} = 4'b0;
    for (int g = 0; g < 4; g++) last_tick[g] = 0;
    repeat (3) @(negedge clock);

    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_x_u%0d", g), int'(xv[g]), xs_of(g));
      chk($sformatf("reset_y_u%0d", g), int'(yv[g]), 112);
      chk($sformatf("reset_tick_mov_u%0d", g), int'({tk[g], mv[g]}), 0);
    end
    reset  = 1'b0;
    enable = 1'b1;

    // hold right from x=0: ramp 1,1,2,2,3,3,3,3
    start_phase(0, 0, 1, 0, 0);
    push_xs(0, '{1, 2, 4, 6, 9, 12, 15, 18}, 1'b1);
    wait_drain(200);

    // both buttons mid-ramp stop the axis; reversal restarts at speed 1
    start_phase(0, 0, 1, 0, 0);
    push_xs(0, '{1, 2, 4, 6, 9}, 1'b1);
    wait_drain(200);
    set_btn(1, 1, 0, 0);
    push(0, 9, 112, 1'b0, 4);
    wait_drain(200);
    set_btn(0, 1, 0, 0);
    push_xs(0, '{10, 11, 13}, 1'b0);
    wait_drain(200);
    set_btn(1, 0, 0, 0);
    push_xs(0, '{12, 11, 9}, 1'b0);
    wait_drain(200);
    set_btn(0, 0, 0, 0);
    push(0, 9, 112, 1'b0, 4);
    wait_drain(200);

    // enable low for 10 clocks one clock after a tick: next tick 14 clocks later
    start_phase(0, 0, 1, 0, 0);
    push(0, 1, 112, 1'b1, 0);
    wait_drain(200);
    @(negedge clock);
    enable = 1'b0;
    repeat (10) @(negedge clock);
    chk("freeze_x", int'(xv[0]), 1);
    chk("freeze_y", int'(yv[0]), 112);
    enable = 1'b1;
    push(0, 2, 112, 1'b1, 14);
    wait_drain(200);
    push(0, 4, 112, 1'b1, 4);
    wait_drain(200);

    // load on the clock that would have ticked: tick swallowed, counter restarts
    repeat (3) @(negedge clock);
    ld[0] = 1'b1;
    @(negedge clock);
    chk("load_x", int'(xv[0]), 0);
    chk("load_y", int'(yv[0]), 112);
    chk("load_tick_mov", int'({tk[0], mv[0]}), 0);
    ld[0] = 1'b0;
    push(0, 1, 112, 1'b1, 8);
    wait_drain(200);

    // asynchronous reset while moving
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("areset_x", int'(xv[0]), 0);
    chk("areset_y", int'(yv[0]), 112);
    chk("areset_tick_mov", int'({tk[0], mv[0]}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push(0, 1, 112, 1'b1, 7);
    wait_drain(200);

    // clamp at x minimum
    start_phase(0, 1, 0, 0, 0);
    push_xs(0, '{0, 0}, 1'b1);
    wait_drain(200);

    // diagonal right+down, y clamps at 119
    start_phase(0, 0, 1, 0, 1);
    push(0, 1, 113, 1'b1, 0);
    push(0, 2, 114, 1'b1, 4);
    push(0, 4, 116, 1'b1, 4);
    push(0, 6, 118, 1'b1, 4);
    push(0, 9, 119, 1'b1, 4);
    wait_drain(200);

    // clamp at x maximum from 158 with speed 3; speed retained while pinned
    start_phase(1, 0, 1, 0, 0);
    push_xs(1, '{147, 148, 150, 152, 155, 158, 160, 160, 160}, 1'b1);
    wait_drain(200);

    // wrap past max: 159 + 3 -> 1
    start_phase(2, 0, 1, 0, 0);
    push_xs(2, '{148, 149, 151, 153, 156, 159, 1, 4}, 1'b1);
    wait_drain(200);

    // wrap past min: 1 - 3 -> 159
    start_phase(3, 1, 0, 0, 0);
    push_xs(3, '{9, 8, 6, 4, 1, 159, 156}, 1'b1);
    wait_drain(200);

    // park everything; any stray tick is flagged by the monitor
    @(negedge clock);
    ld = 4'hF;
    {b_l, b_r, b_u, b_d} = 4'b0;
    repeat (12) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
